// File: rtl/lzw_pkg.sv
// lzw_pkg: shared definitions for the LZW dictionary controller.
//   - default widths and first allocatable code
//   - controller state encoding
//   - packed main-table entry layout {valid, key, code}
package lzw_pkg;

  localparam int LZW_DATA_WIDTH = 64;
  localparam int LZW_HASH_WIDTH = 12;
  localparam int LZW_CODE_WIDTH = 12;
  localparam int FIRST_CODE     = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HT_CHK  = 3'd1,
    CT_LK   = 3'd2,
    CT_WAIT = 3'd3,
    HT_WR   = 3'd4,
    CT_WR   = 3'd5,
    RESP    = 3'd6
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic [LZW_DATA_WIDTH-1:0] key;
    logic [LZW_CODE_WIDTH-1:0] code;
  } ht_entry_t;

  // Builds a valid main-table entry from a key and its code.
  function automatic ht_entry_t make_entry(input logic [LZW_DATA_WIDTH-1:0] key,
                                           input logic [LZW_CODE_WIDTH-1:0] code);
    ht_entry_t e;
    e.valid = 1'b1;
    e.key   = key;
    e.code  = code;
    return e;
  endfunction

endpackage

// File: rtl/lzw_code_alloc.sv
// lzw_code_alloc: dictionary code allocator.
//   Holds the next code to hand out. alloc_i advances it by one unless the
//   code space is exhausted. The all-ones code is reserved and never handed
//   out, so the allocator reports full once next_code reaches it.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   alloc_i        consume next_code_o this cycle
//   next_code_o    code that the next allocation will return
//   dict_full_o    next_code_o is the reserved all-ones value
module lzw_code_alloc #(
  parameter int CODE_WIDTH = lzw_pkg::LZW_CODE_WIDTH,
  parameter int FIRST_CODE = lzw_pkg::FIRST_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_i,
  output logic [CODE_WIDTH-1:0] next_code_o,
  output logic                  dict_full_o
);

  logic [CODE_WIDTH-1:0] code_q;
  logic [CODE_WIDTH-1:0] code_d;
  logic                  full_w;

  assign full_w = (code_q == {CODE_WIDTH{1'b1}});

  always_comb begin
    code_d = code_q;
    if (alloc_i && !full_w) begin
      code_d = code_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= CODE_WIDTH'(FIRST_CODE);
    end else begin
      code_q <= code_d;
    end
  end

  assign next_code_o = code_q;
  assign dict_full_o = full_w;

endmodule

// File: rtl/lzw_dict_ctrl.sv
// lzw_dict_ctrl: LZW dictionary lookup/insert sequencer.
//   Takes one {prefix, byte} key per request, probes the main hash table,
//   falls back to the conflict table when the main slot holds another key,
//   and either returns the stored code or allocates and inserts a new one.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_key/req_hash/req_insert  key, its precomputed hash, insert-on-miss
//   resp_valid/resp_ready        response handshake
//   resp_hit/resp_inserted       lookup outcome
//   resp_code                    hit or new code, 0 otherwise
//   dict_full                    code space exhausted
//   ct_overflow                  sticky: insert dropped, conflict table full
//   ht_en/ht_we/ht_addr/ht_wdata main-table access (registered read RAM)
//   ht_rdata                     main-table read data {valid, key, code}
//   ct_cs/ct_we/ct_data          conflict-table access
//   ct_hash_in                   code written into the conflict table
//   ct_match                     combinational match flag
//   ct_hash_out                  matched code, one cycle after ct_match
//   ct_full                      conflict table has no free entry
// All outputs are registered.
module lzw_dict_ctrl #(
  parameter int DATA_WIDTH = lzw_pkg::LZW_DATA_WIDTH,
  parameter int HASH_WIDTH = lzw_pkg::LZW_HASH_WIDTH,
  parameter int CODE_WIDTH = lzw_pkg::LZW_CODE_WIDTH,
  parameter int FIRST_CODE = lzw_pkg::FIRST_CODE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [DATA_WIDTH-1:0]            req_key,
  input  logic [HASH_WIDTH-1:0]            req_hash,
  input  logic                             req_insert,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             resp_hit,
  output logic                             resp_inserted,
  output logic [CODE_WIDTH-1:0]            resp_code,
  output logic                             dict_full,
  output logic                             ct_overflow,
  output logic                             ht_en,
  output logic                             ht_we,
  output logic [HASH_WIDTH-1:0]            ht_addr,
  output logic [DATA_WIDTH+CODE_WIDTH:0]   ht_wdata,
  input  logic [DATA_WIDTH+CODE_WIDTH:0]   ht_rdata,
  output logic                             ct_cs,
  output logic                             ct_we,
  output logic [DATA_WIDTH-1:0]            ct_data,
  output logic [HASH_WIDTH-1:0]            ct_hash_in,
  input  logic                             ct_match,
  input  logic [HASH_WIDTH-1:0]            ct_hash_out,
  input  logic                             ct_full
);

  import lzw_pkg::*;

  localparam int ENTRY_W = 1 + DATA_WIDTH + CODE_WIDTH;

  // Latched request and internal state
  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [HASH_WIDTH-1:0]   hash_q;
  logic                    insert_q;
  logic                    ht_pend_q;   // main-table read issued, data not back yet
  logic                    match_q;
  logic [CODE_WIDTH-1:0]   code_q;      // code reserved by the pending insert

  // Registered outputs
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_hit_q;
  logic                    resp_inserted_q;
  logic [CODE_WIDTH-1:0]   resp_code_q;
  logic                    ct_overflow_q;
  logic                    ht_en_q;
  logic                    ht_we_q;
  logic [HASH_WIDTH-1:0]   ht_addr_q;
  logic [ENTRY_W-1:0]      ht_wdata_q;
  logic                    ct_cs_q;
  logic                    ct_we_q;
  logic [DATA_WIDTH-1:0]   ct_data_q;
  logic [HASH_WIDTH-1:0]   ct_hash_in_q;

  // Main-table read data fields
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_key;
  logic [CODE_WIDTH-1:0]   rd_code;
  logic                    rd_hit;

  logic [CODE_WIDTH-1:0]   next_code;
  logic                    dict_full_w;
  logic                    ht_chk_live;
  logic                    ht_ins_go;
  logic                    ct_ins_go;
  logic                    alloc;

  assign rd_valid = ht_rdata[ENTRY_W-1];
  assign rd_key   = ht_rdata[CODE_WIDTH +: DATA_WIDTH];
  assign rd_code  = ht_rdata[CODE_WIDTH-1:0];
  assign rd_hit   = rd_valid && (rd_key == key_q);

  // HT_CHK spends its first cycle waiting for the registered RAM read.
  assign ht_chk_live = (state_q == HT_CHK) && !ht_pend_q;
  assign ht_ins_go   = ht_chk_live && !rd_valid && insert_q && !dict_full_w;
  assign ct_ins_go   = (state_q == CT_WAIT) && !match_q && insert_q
                       && !dict_full_w && !ct_full;

  // The code is taken on the edge that commits to a write state, so the
  // write data and the response both carry the same value.
  assign alloc = ht_ins_go || ct_ins_go;

  lzw_code_alloc #(
    .CODE_WIDTH (CODE_WIDTH),
    .FIRST_CODE (FIRST_CODE)
  ) u_alloc (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc),
    .next_code_o (next_code),
    .dict_full_o (dict_full_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      key_q           <= '0;
      hash_q          <= '0;
      insert_q        <= 1'b0;
      ht_pend_q       <= 1'b0;
      match_q         <= 1'b0;
      code_q          <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_inserted_q <= 1'b0;
      resp_code_q     <= '0;
      ct_overflow_q   <= 1'b0;
      ht_en_q         <= 1'b0;
      ht_we_q         <= 1'b0;
      ht_addr_q       <= '0;
      ht_wdata_q      <= '0;
      ct_cs_q         <= 1'b0;
      ct_we_q         <= 1'b0;
      ct_data_q       <= '0;
      ct_hash_in_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            key_q       <= req_key;
            hash_q      <= req_hash;
            insert_q    <= req_insert;
            ht_en_q     <= 1'b1;
            ht_we_q     <= 1'b0;
            ht_addr_q   <= req_hash;
            ht_pend_q   <= 1'b1;
            state_q     <= HT_CHK;
          end
        end

        HT_CHK: begin
          if (ht_pend_q) begin
            ht_en_q   <= 1'b0;
            ht_pend_q <= 1'b0;
          end else if (rd_hit) begin
            resp_valid_q    <= 1'b1;
            resp_hit_q      <= 1'b1;
            resp_inserted_q <= 1'b0;
            resp_code_q     <= rd_code;
            state_q         <= RESP;
          end else if (!rd_valid) begin
            if (ht_ins_go) begin
              ht_en_q    <= 1'b1;
              ht_we_q    <= 1'b1;
              ht_addr_q  <= hash_q;
              ht_wdata_q <= {1'b1, key_q, next_code};
              code_q     <= next_code;
              state_q    <= HT_WR;
            end else begin
              resp_valid_q    <= 1'b1;
              resp_hit_q      <= 1'b0;
              resp_inserted_q <= 1'b0;
              resp_code_q     <= '0;
              state_q         <= RESP;
            end
          end else begin
            // Slot taken by a different key: try the conflict table.
            ct_cs_q   <= 1'b1;
            ct_we_q   <= 1'b0;
            ct_data_q <= key_q;
            state_q   <= CT_LK;
          end
        end

        CT_LK: begin
          match_q <= ct_match;
          state_q <= CT_WAIT;
        end

        CT_WAIT: begin
          if (match_q) begin
            ct_cs_q         <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_hit_q      <= 1'b1;
            resp_inserted_q <= 1'b0;
            resp_code_q     <= ct_hash_out;
            state_q         <= RESP;
          end else if (ct_ins_go) begin
            ct_we_q      <= 1'b1;
            ct_hash_in_q <= next_code;
            code_q       <= next_code;
            state_q      <= CT_WR;
          end else begin
            if (insert_q && !dict_full_w && ct_full) begin
              ct_overflow_q <= 1'b1;
            end
            ct_cs_q         <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_hit_q      <= 1'b0;
            resp_inserted_q <= 1'b0;
            resp_code_q     <= '0;
            state_q         <= RESP;
          end
        end

        HT_WR: begin
          ht_en_q         <= 1'b0;
          ht_we_q         <= 1'b0;
          resp_valid_q    <= 1'b1;
          resp_hit_q      <= 1'b0;
          resp_inserted_q <= 1'b1;
          resp_code_q     <= code_q;
          state_q         <= RESP;
        end

        CT_WR: begin
          ct_cs_q         <= 1'b0;
          ct_we_q         <= 1'b0;
          resp_valid_q    <= 1'b1;
          resp_hit_q      <= 1'b0;
          resp_inserted_q <= 1'b1;
          resp_code_q     <= code_q;
          state_q         <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_inserted_q <= 1'b0;
            resp_code_q     <= '0;
            req_ready_q     <= 1'b1;
            state_q         <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_inserted = resp_inserted_q;
  assign resp_code     = resp_code_q;
  assign dict_full     = dict_full_w;
  assign ct_overflow   = ct_overflow_q;
  assign ht_en         = ht_en_q;
  assign ht_we         = ht_we_q;
  assign ht_addr       = ht_addr_q;
  assign ht_wdata      = ht_wdata_q;
  assign ct_cs         = ct_cs_q;
  assign ct_we         = ct_we_q;
  assign ct_data       = ct_data_q;
  assign ct_hash_in    = ct_hash_in_q;

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// Bench for lzw_dict_ctrl: main-table RAM and conflict-table models,
// table-driven lookups checked through a response scoreboard, plus
// hand-written sequences for back-pressure, reset abort and code exhaustion.
module tb_lzw_dict_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_insert;
  logic [63:0]  req_key;
  logic [11:0]  req_hash;
  logic         resp_valid, resp_ready, resp_hit, resp_inserted;
  logic [11:0]  resp_code;
  logic         dict_full, ct_overflow;
  logic         ht_en, ht_we;
  logic [11:0]  ht_addr;
  logic [76:0]  ht_wdata;
  logic [76:0]  ht_rdata;
  logic         ct_cs, ct_we, ct_match, ct_full;
  logic [63:0]  ct_data;
  logic [11:0]  ct_hash_in, ct_hash_out;

  always #5 clk = ~clk;

  lzw_dict_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_hash(req_hash), .req_insert(req_insert),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_inserted(resp_inserted), .resp_code(resp_code),
    .dict_full(dict_full), .ct_overflow(ct_overflow),
    .ht_en(ht_en), .ht_we(ht_we), .ht_addr(ht_addr), .ht_wdata(ht_wdata),
    .ht_rdata(ht_rdata),
    .ct_cs(ct_cs), .ct_we(ct_we), .ct_data(ct_data), .ct_hash_in(ct_hash_in),
    .ct_match(ct_match), .ct_hash_out(ct_hash_out), .ct_full(ct_full)
  );

  // ---------------- storage models ----------------
  bit [76:0] mem [4096];
  always @(posedge clk) begin
    if (ht_en) begin
      if (ht_we) mem[ht_addr] <= ht_wdata;
      else       ht_rdata     <= mem[ht_addr];
    end
  end

  bit [63:0] ct_key [8];
  bit [11:0] ct_code [8];
  bit        ct_vld [8];
  int        ct_cnt = 0;
  bit        ct_full_force = 1'b0;
  logic      ct_match_c;
  logic [11:0] ct_hit_code;

  always_comb begin
    ct_match_c  = 1'b0;
    ct_hit_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (ct_vld[i] && ct_key[i] == ct_data) begin
        ct_match_c  = 1'b1;
        ct_hit_code = ct_code[i];
      end
    end
  end
  assign ct_match = ct_cs & ~ct_we & ct_match_c;
  assign ct_full  = ct_full_force | (ct_cnt == 8);

  always @(posedge clk) begin
    if (ct_cs && !ct_we) ct_hash_out <= ct_hit_code;
    if (ct_cs && ct_we && ct_cnt < 8) begin
      ct_key[ct_cnt]  <= ct_data;
      ct_code[ct_cnt] <= ct_hash_in;
      ct_vld[ct_cnt]  <= 1'b1;
      ct_cnt          <= ct_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          hit;
    bit          ins;
    logic [11:0] code;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          resp_cnt = 0;
  int          htw_cnt = 0;
  int          ctw_cnt = 0;
  logic [11:0] last_htw_addr;
  logic [76:0] last_htw_data;
  logic [63:0] last_ctw_data;
  logic [11:0] last_ctw_hash;
  bit          seen = 1'b0;
  logic [13:0] held;

  // Response monitor: pops the scoreboard on the first resp_valid cycle,
  // then requires the payload to stay put while the consumer stalls.
  always @(negedge clk) begin
    exp_t e;
    if (ht_en && ht_we) begin
      htw_cnt++; last_htw_addr = ht_addr; last_htw_data = ht_wdata;
    end
    if (ct_cs && ct_we) begin
      ctw_cnt++; last_ctw_data = ct_data; last_ctw_hash = ct_hash_in;
    end
    if (resp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = {resp_hit, resp_inserted, resp_code};
        resp_cnt++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_resp: got hit=%0d ins=%0d code=%0d with nothing pending",
                   resp_hit, resp_inserted, resp_code);
        end else begin
          e = sb.pop_front();
          chk("resp_hit", resp_hit, e.hit);
          chk("resp_inserted", resp_inserted, e.ins);
          chk("resp_code", resp_code, e.code);
          chk("latency", cyc - e.acc, e.lat);
          $display("resp #%0d hit=%0d ins=%0d code=%0d lat=%0d", resp_cnt,
                   resp_hit, resp_inserted, resp_code, cyc - e.acc);
        end
      end else begin
        chk("resp_stable", {resp_hit, resp_inserted, resp_code}, held);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic outs_zero(input string nm);
    chk({nm, "_ctl"},
        {req_ready, resp_valid, resp_hit, resp_inserted, resp_code, dict_full,
         ct_overflow, ht_en, ht_we, ht_addr, ct_cs, ct_we, ct_data, ct_hash_in}, 0);
    chk({nm, "_wdata"}, ht_wdata, 0);
  endtask

  // Drives one request from a negedge; returns #1 after the accept edge.
  task automatic send(input logic [63:0] k, input logic [11:0] h, input bit ins,
                      input bit eh, input bit ei, input logic [11:0] ec, input int el);
    int w = 0;
    req_key = k; req_hash = h; req_insert = ins; req_valid = 1'b1;
    while (!req_ready && w < 50) begin
      @(negedge clk); w++;
    end
    chk("req_ready_wait", req_ready, 1);
    sb.push_back('{eh, ei, ec, el, cyc + 1});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int r0);
    int w = 0;
    while (!(resp_cnt > r0 && req_ready) && w < 40) begin
      @(negedge clk); w++;
    end
    chk("resp_done", (resp_cnt > r0) && req_ready, 1);
  endtask

  typedef struct {
    logic [63:0] key;
    logic [11:0] hash;
    bit          ins;
    bit          ctf;
    bit          e_hit;
    bit          e_ins;
    logic [11:0] e_code;
    int          e_lat;
    int          e_htw;
    int          e_ctw;
    bit          e_ovf;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, hw0, cw0, h;
    logic [76:0] exp_w;

    //           key            hash     ins ctf hit ins code   lat htw ctw ovf
    tbl[0] = '{64'h41_0061, 12'h123, 1, 0,  0,  1, 12'd256, 3, 1, 0, 0};
    tbl[1] = '{64'h41_0061, 12'h123, 1, 0,  1,  0, 12'd256, 2, 0, 0, 0};
    tbl[2] = '{64'h42_0062, 12'h123, 1, 0,  0,  1, 12'd257, 5, 0, 1, 0};
    tbl[3] = '{64'h42_0062, 12'h123, 1, 0,  1,  0, 12'd257, 4, 0, 0, 0};
    tbl[4] = '{64'h43_0063, 12'h123, 0, 0,  0,  0, 12'd0,   4, 0, 0, 0};
    tbl[5] = '{64'h44_0064, 12'h055, 0, 0,  0,  0, 12'd0,   2, 0, 0, 0};
    tbl[6] = '{64'h44_0064, 12'h055, 1, 0,  0,  1, 12'd258, 3, 1, 0, 0};
    tbl[7] = '{64'h45_0065, 12'h123, 1, 1,  0,  0, 12'd0,   4, 0, 0, 1};
    tbl[8] = '{64'h41_0061, 12'h123, 1, 0,  1,  0, 12'd256, 2, 0, 0, 1};

    rst = 1'b1; req_valid = 1'b0; req_key = '0; req_hash = '0; req_insert = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);

    // ---- table-driven lookups ----
    for (int i = 0; i < 9; i++) begin
      ct_full_force = tbl[i].ctf;
      hw0 = htw_cnt; cw0 = ctw_cnt; r0 = resp_cnt;
      send(tbl[i].key, tbl[i].hash, tbl[i].ins, tbl[i].e_hit, tbl[i].e_ins,
           tbl[i].e_code, tbl[i].e_lat);
      wait_done(r0);
      chk("ht_writes", htw_cnt - hw0, tbl[i].e_htw);
      chk("ct_writes", ctw_cnt - cw0, tbl[i].e_ctw);
      chk("ct_overflow", ct_overflow, tbl[i].e_ovf);
      if (tbl[i].e_htw == 1) begin
        exp_w = lzw_pkg::make_entry(tbl[i].key, tbl[i].e_code);
        chk("ht_wr_addr", last_htw_addr, tbl[i].hash);
        chk("ht_wr_data", last_htw_data, exp_w);
      end
      if (tbl[i].e_ctw == 1) begin
        chk("ct_wr_data", last_ctw_data, tbl[i].key);
        chk("ct_wr_code", last_ctw_hash, tbl[i].e_code);
      end
    end
    ct_full_force = 1'b0;

    // ---- consumer back-pressure ----
    resp_ready = 1'b0;
    r0 = resp_cnt;
    send(64'h44_0064, 12'h055, 1'b0, 1'b1, 1'b0, 12'd258, 2);
    for (int w = 0; w < 20 && resp_cnt == r0; w++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("release_resp_valid", resp_valid, 0);
    chk("release_req_ready", req_ready, 1);

    // ---- reset while waiting on the conflict table ----
    req_key = 64'h9999; req_hash = 12'h123; req_insert = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ct_wait_cs", ct_cs, 1);
    hw0 = htw_cnt; cw0 = ctw_cnt; r0 = resp_cnt;
    rst = 1'b1;
    #1;
    outs_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_ht_writes", htw_cnt - hw0, 0);
    chk("abort_ct_writes", ctw_cnt - cw0, 0);
    chk("abort_resps", resp_cnt - r0, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_ct_overflow", ct_overflow, 0);

    // ---- exhaust the code space: codes 256..4094 ----
    h = 12'h200;
    for (int i = 0; i < 3839; i++) begin
      if (h == 12'h055 || h == 12'h123) h = (h + 1) % 4096;
      if (i == 3838) chk("dict_full_before_last", dict_full, 0);
      r0 = resp_cnt;
      send(64'h0100_0000 + 64'(i), 12'(h), 1'b1, 1'b0, 1'b1, 12'(256 + i), 3);
      wait_done(r0);
      h = (h + 1) % 4096;
    end
    chk("dict_full", dict_full, 1);

    // Miss into an empty slot once full: nothing allocated or written.
    if (h == 12'h055 || h == 12'h123) h = (h + 1) % 4096;
    hw0 = htw_cnt; r0 = resp_cnt;
    send(64'h7777, 12'(h), 1'b1, 1'b0, 1'b0, 12'd0, 2);
    wait_done(r0);
    chk("full_ht_writes", htw_cnt - hw0, 0);

    // Colliding miss once full: no conflict write and no overflow flag.
    cw0 = ctw_cnt; r0 = resp_cnt;
    send(64'h9999, 12'h123, 1'b1, 1'b0, 1'b0, 12'd0, 4);
    wait_done(r0);
    chk("full_ct_writes", ctw_cnt - cw0, 0);
    chk("full_ct_overflow", ct_overflow, 0);
    chk("dict_full_held", dict_full, 1);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
